branch_ctrl: RTL and testbench

Branch prediction and redirect controller for the 5-stage RV32I pipeline. Predicts taken/not-taken and target for the fetch PC from a direct-mapped BTB with 2-bit saturating counters. Compares the prediction carried down the pipeline with the EX-stage branch resolver's `branch_taken`, then drives PC redirect and IF/ID, ID/EX flushes. Trains the predictor and keeps branch and mispredict statistics.

---
 rtl/branch_ctrl.sv | 164 ++++++++++++++++
 tb/tb_branch_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// branch_ctrl
//   Branch prediction and redirect controller for a 5-stage RV32I pipeline.
//   A direct-mapped BTB with 2-bit saturating counters predicts the fetch PC.
//   The prediction is carried down the pipe and compared against the EX-stage
//   resolver; on a mismatch, fetch is redirected and IF/ID, ID/EX are flushed.
//   The table is trained and the statistics counters are updated at the edge
//   that ends the EX cycle.
//
// Ports
//   clk, reset_n                     clock, async active-low reset
//   if_valid, if_pc                  fetch lookup request
//   pred_taken, pred_target          prediction for if_pc (target 0 if not taken)
//   ex_valid, ex_aluSelect, ex_pc    EX instruction info
//   ex_target, ex_branch_taken       resolver results
//   ex_pred_taken, ex_pred_target    prediction carried from IF
//   redirect, redirect_pc            fetch redirect request
//   flush_if_id, flush_id_ex         squash pipeline registers
//   stat_branches, stat_mispredicts  wrapping event counters
//
// States
//   state  | meaning
//   IDLE   | evaluate and train from the EX stage
//   SQUASH | cycle after a redirect; EX holds a squashed slot, ignore it

module branch_ctrl #(
    parameter int IDX_BITS = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic [5:0]  ex_aluSelect,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_branch_taken,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = 30 - IDX_BITS;

    typedef enum logic {
        IDLE   = 1'b0,
        SQUASH = 1'b1
    } state_t;

    state_t state_q;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];
    logic              jump_q   [ENTRIES];

    // Fetch-side lookup
    logic [IDX_BITS-1:0] if_idx;
    logic [TAG_W-1:0]    if_tag;
    logic                if_hit;
    logic                unused_if_pc_bits;

    assign if_idx = if_pc[IDX_BITS+1:2];
    assign if_tag = if_pc[31:IDX_BITS+2];
    assign unused_if_pc_bits = ^if_pc[1:0];

    assign if_hit      = if_valid & valid_q[if_idx] & (tag_q[if_idx] == if_tag);
    assign pred_taken  = if_hit & (jump_q[if_idx] | ctr_q[if_idx][1]);
    assign pred_target = pred_taken ? target_q[if_idx] : 32'h0;

    // EX-side classification and mispredict detection
    logic [IDX_BITS-1:0] ex_idx;
    logic [TAG_W-1:0]    ex_tag;
    logic                ex_hit;
    logic                is_ctl;
    logic                is_jump;
    logic                actual;
    logic                ex_active;
    logic                mispredict;
    logic [1:0]          ctr_cur;
    logic [1:0]          ctr_new;

    assign ex_idx  = ex_pc[IDX_BITS+1:2];
    assign ex_tag  = ex_pc[31:IDX_BITS+2];
    assign ex_hit  = valid_q[ex_idx] & (tag_q[ex_idx] == ex_tag);
    assign is_ctl  = (ex_aluSelect >= 6'd3) && (ex_aluSelect <= 6'd10);
    assign is_jump = (ex_aluSelect == 6'd3) || (ex_aluSelect == 6'd4);
    assign actual  = is_ctl & ex_branch_taken;

    // reset_n gating keeps the redirect outputs quiet while reset is held
    assign ex_active  = ex_valid & reset_n & (state_q == IDLE);
    assign mispredict = ex_active &
                        ((ex_pred_taken != actual) |
                         (actual & (ex_pred_target != ex_target)));

    assign redirect    = mispredict;
    assign flush_if_id = mispredict;
    assign flush_id_ex = mispredict;
    assign redirect_pc = mispredict ? (actual ? ex_target : ex_pc + 32'd4) : 32'h0;

    // Counter update: saturate on a hit, reinitialise weakly on a miss/alias
    assign ctr_cur = ctr_q[ex_idx];

    always_comb begin
        ctr_new = ctr_cur;
        if (ex_hit) begin
            if (actual) begin
                ctr_new = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'd1;
            end else begin
                ctr_new = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'd1;
            end
        end else begin
            ctr_new = actual ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            stat_branches    <= 32'h0;
            stat_mispredicts <= 32'h0;
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'h0;
                ctr_q[i]    <= 2'b01;
                jump_q[i]   <= 1'b0;
            end
        end else begin
            case (state_q)
                IDLE:    if (mispredict) state_q <= SQUASH;
                SQUASH:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            if (ex_active) begin
                if (is_ctl) begin
                    valid_q[ex_idx]  <= 1'b1;
                    tag_q[ex_idx]    <= ex_tag;
                    target_q[ex_idx] <= ex_target;
                    jump_q[ex_idx]   <= is_jump;
                    ctr_q[ex_idx]    <= ctr_new;
                    stat_branches    <= stat_branches + 32'd1;
                end else if (ex_pred_taken) begin
                    // a non-control instruction was predicted taken: stale alias
                    valid_q[ex_idx] <= 1'b0;
                end
            end

            if (mispredict) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl
//   Scoreboard bench for branch_ctrl. Each EX stimulus pushes its expected
//   redirect outcome; the outcome is popped and compared mid-cycle.

module tb_branch_ctrl;

    localparam logic [5:0] SEL_JAL  = 6'b000011;
    localparam logic [5:0] SEL_JALR = 6'b000100;
    localparam logic [5:0] SEL_BEQ  = 6'b000101;
    localparam logic [5:0] SEL_ALU  = 6'b000000;
    localparam logic [5:0] SEL_ABOVE = 6'b001011;

    logic        clk;
    logic        reset_n;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [5:0]  ex_aluSelect;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_branch_taken;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    branch_ctrl #(.IDX_BITS(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .if_valid         (if_valid),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex_valid         (ex_valid),
        .ex_aluSelect     (ex_aluSelect),
        .ex_pc            (ex_pc),
        .ex_target        (ex_target),
        .ex_branch_taken  (ex_branch_taken),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .flush_if_id      (flush_if_id),
        .flush_id_ex      (flush_id_ex),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        redir;
        logic [31:0] rpc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sb_check();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({e.name, ".redirect"},    {31'd0, redirect},    {31'd0, e.redir});
            chk({e.name, ".redirect_pc"}, redirect_pc,          e.rpc);
            chk({e.name, ".flush_if_id"}, {31'd0, flush_if_id}, {31'd0, e.redir});
            chk({e.name, ".flush_id_ex"}, {31'd0, flush_id_ex}, {31'd0, e.redir});
        end
    endtask

    task automatic ex_drive(input string name, input logic v, input logic [5:0] sel,
                            input logic [31:0] pc, input logic [31:0] tgt,
                            input logic tk, input logic ptk, input logic [31:0] ptgt,
                            input logic e_redir, input logic [31:0] e_rpc);
        exp_t e;
        ex_valid        = v;
        ex_aluSelect    = sel;
        ex_pc           = pc;
        ex_target       = tgt;
        ex_branch_taken = tk;
        ex_pred_taken   = ptk;
        ex_pred_target  = ptgt;
        e.name  = name;
        e.redir = e_redir;
        e.rpc   = e_rpc;
        exp_q.push_back(e);
    endtask

    task automatic ex_clear();
        ex_valid        = 1'b0;
        ex_aluSelect    = 6'd0;
        ex_pc           = 32'h0;
        ex_target       = 32'h0;
        ex_branch_taken = 1'b0;
        ex_pred_taken   = 1'b0;
        ex_pred_target  = 32'h0;
    endtask

    task automatic ex_cycle(input string name, input logic v, input logic [5:0] sel,
                            input logic [31:0] pc, input logic [31:0] tgt,
                            input logic tk, input logic ptk, input logic [31:0] ptgt,
                            input logic e_redir, input logic [31:0] e_rpc);
        ex_drive(name, v, sel, pc, tgt, tk, ptk, ptgt, e_redir, e_rpc);
        @(negedge clk);
        sb_check();
        @(posedge clk);
        #1;
        ex_clear();
    endtask

    task automatic if_check(input string name, input logic v, input logic [31:0] pc,
                            input logic e_taken, input logic [31:0] e_tgt);
        if_valid = v;
        if_pc    = pc;
        @(negedge clk);
        chk({name, ".pred_taken"},  {31'd0, pred_taken}, {31'd0, e_taken});
        chk({name, ".pred_target"}, pred_target,         e_tgt);
        @(posedge clk);
        #1;
        if_valid = 1'b0;
    endtask

    task automatic stat_check(input string name, input logic [31:0] e_br, input logic [31:0] e_mp);
        @(negedge clk);
        chk({name, ".stat_branches"},    stat_branches,    e_br);
        chk({name, ".stat_mispredicts"}, stat_mispredicts, e_mp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        if_valid = 1'b1;
        if_pc    = 32'h100;
        ex_clear();

        #3;
        chk("reset.pred_taken",  {31'd0, pred_taken}, 32'd0);
        chk("reset.pred_target", pred_target, 32'd0);
        chk("reset.redirect",    {31'd0, redirect}, 32'd0);
        chk("reset.redirect_pc", redirect_pc, 32'd0);
        chk("reset.stat_br",     stat_branches, 32'd0);
        chk("reset.stat_mp",     stat_mispredicts, 32'd0);

        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        if_check("miss_after_reset", 1'b1, 32'h100, 1'b0, 32'h0);

        // cold taken BEQ, then a would-be mispredict in the SQUASH slot
        ex_cycle("cold_beq", 1'b1, SEL_BEQ, 32'h100, 32'h80, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80);
        ex_cycle("squash_ignored", 1'b1, SEL_BEQ, 32'h104, 32'h300, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        stat_check("after_cold", 32'd1, 32'd1);
        if_check("pred_0x100", 1'b1, 32'h100, 1'b1, 32'h80);
        if_check("if_valid_low", 1'b0, 32'h100, 1'b0, 32'h0);
        if_check("no_train_in_squash", 1'b1, 32'h104, 1'b0, 32'h0);

        // counter walk 10 -> 01 -> 00 -> 00, then back up 00 -> 01 -> 10
        ex_cycle("nt1", 1'b1, SEL_BEQ, 32'h100, 32'h80, 1'b0, 1'b1, 32'h80, 1'b1, 32'h104);
        idle();
        if_check("ctr01", 1'b1, 32'h100, 1'b0, 32'h0);
        ex_cycle("nt2", 1'b1, SEL_BEQ, 32'h100, 32'h80, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        ex_cycle("nt3", 1'b1, SEL_BEQ, 32'h100, 32'h80, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        if_check("ctr00", 1'b1, 32'h100, 1'b0, 32'h0);
        ex_cycle("tk_from00", 1'b1, SEL_BEQ, 32'h100, 32'h80, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80);
        idle();
        if_check("ctr01_again", 1'b1, 32'h100, 1'b0, 32'h0);
        ex_cycle("tk_from01", 1'b1, SEL_BEQ, 32'h100, 32'h80, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80);
        idle();
        if_check("ctr10", 1'b1, 32'h100, 1'b1, 32'h80);
        stat_check("after_sat", 32'd6, 32'd4);

        ex_cycle("ex_valid_low", 1'b0, SEL_BEQ, 32'h100, 32'h80, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

        // JALR wrong target, then a correct prediction; JAL with counter 01
        ex_cycle("jalr_cold", 1'b1, SEL_JALR, 32'h308, 32'h200, 1'b1, 1'b0, 32'h0, 1'b1, 32'h200);
        idle();
        if_check("jalr_pred", 1'b1, 32'h308, 1'b1, 32'h200);
        ex_cycle("jalr_wrong_tgt", 1'b1, SEL_JALR, 32'h308, 32'h240, 1'b1, 1'b1, 32'h200, 1'b1, 32'h240);
        idle();
        if_check("jalr_retarget", 1'b1, 32'h308, 1'b1, 32'h240);
        ex_cycle("jalr_correct", 1'b1, SEL_JALR, 32'h308, 32'h240, 1'b1, 1'b1, 32'h240, 1'b0, 32'h0);
        ex_cycle("jal_nt", 1'b1, SEL_JAL, 32'h40C, 32'h500, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        if_check("jump_flag", 1'b1, 32'h40C, 1'b1, 32'h500);

        // aliases: non-control predicted taken
        ex_cycle("alias", 1'b1, SEL_ABOVE, 32'h100, 32'h80, 1'b1, 1'b1, 32'h80, 1'b1, 32'h104);
        idle();
        if_check("alias_cleared", 1'b1, 32'h100, 1'b0, 32'h0);
        ex_cycle("alias_wrap", 1'b1, SEL_ALU, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b1, 32'h1234, 1'b1, 32'h0);
        idle();
        ex_cycle("nonctl_untouched", 1'b1, SEL_ALU, 32'h40C, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        if_check("jal_kept", 1'b1, 32'h40C, 1'b1, 32'h500);
        stat_check("after_alias", 32'd10, 32'd8);

        // same-index IF read and EX write: IF sees the old entry
        if_valid = 1'b1;
        if_pc    = 32'h40C;
        ex_drive("hazard", 1'b1, SEL_BEQ, 32'h80C, 32'h900, 1'b1, 1'b0, 32'h0, 1'b1, 32'h900);
        @(negedge clk);
        sb_check();
        chk("hazard_old.pred_taken", {31'd0, pred_taken}, 32'd1);
        chk("hazard_old.pred_target", pred_target, 32'h500);
        @(posedge clk);
        #1;
        ex_clear();
        if_valid = 1'b0;
        ex_cycle("hazard_squash_jal", 1'b1, SEL_JAL, 32'h600, 32'h700, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        if_check("hazard_evicted", 1'b1, 32'h40C, 1'b0, 32'h0);
        if_check("hazard_new", 1'b1, 32'h80C, 1'b1, 32'h900);
        stat_check("after_hazard", 32'd11, 32'd9);

        // mid-operation reset clears without a clock edge
        if_valid = 1'b1;
        if_pc    = 32'h80C;
        reset_n  = 1'b0;
        #2;
        chk("midreset.pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("midreset.stat_br", stat_branches, 32'd0);
        chk("midreset.stat_mp", stat_mispredicts, 32'd0);
        chk("midreset.redirect", {31'd0, redirect}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        if_check("post_reset_miss", 1'b1, 32'h80C, 1'b0, 32'h0);

        chk("sb_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
